// File: rtl/run_detect_fsm.sv
// rtl/run_detect_fsm.sv - Moore detector flagging RUN_LEN consecutive equal samples of w
module run_detect_fsm #(
  parameter int RUN_LEN = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic w,
  output logic z
);

  localparam int             CW    = $clog2(RUN_LEN + 1);
  localparam logic [CW-1:0]  C_MAX = CW'(RUN_LEN);

  // Reject unsupported run lengths when the design is elaborated
  generate
    if (RUN_LEN < 2 || RUN_LEN > 16) begin : g_bad_run_len
      $error("run_detect_fsm: RUN_LEN must be in 2..16");
    end
  endgenerate

  // S_IDLE: no history; S_RUN: run shorter than RUN_LEN; S_HIT: run saturated at RUN_LEN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HIT  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_run_cnt;
  logic [CW-1:0]   w_cnt_next;
  logic            r_last_w;

  // State, run counter and previous sample; reset wipes all history
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_run_cnt <= '0;
      r_last_w  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_run_cnt <= w_cnt_next;
      r_last_w  <= w;
    end
  end

  // Next-state: restart the run on a differing sample, count up to RUN_LEN, then hold
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_run_cnt;
    case (r_state)
      S_IDLE: begin
        // The zero left in r_last_w by reset is not a real sample
        w_state_next = S_RUN;
        w_cnt_next   = CW'(1);
      end
      S_RUN: begin
        if (w != r_last_w) begin
          w_cnt_next = CW'(1);
        end else begin
          w_cnt_next = r_run_cnt + 1'b1;
          if (w_cnt_next == C_MAX) begin
            w_state_next = S_HIT;
          end
        end
      end
      S_HIT: begin
        if (w != r_last_w) begin
          w_state_next = S_RUN;
          w_cnt_next   = CW'(1);
        end else begin
          w_cnt_next   = C_MAX;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Moore output: decoded from registered state only, never from the live w
  assign z = (r_state == S_HIT);

endmodule

// File: tb/tb_run_detect_fsm.sv
// tb/tb_run_detect_fsm.sv - table-driven self-checking bench for run_detect_fsm
module tb_run_detect_fsm;

  logic clk = 1'b0;
  logic reset2 = 1'b1;
  logic w2 = 1'b0;
  logic z2;
  logic reset4 = 1'b1;
  logic w4 = 1'b0;
  logic z4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  run_detect_fsm #(.RUN_LEN(2)) u_dut2 (
    .clk   (clk),
    .reset (reset2),
    .w     (w2),
    .z     (z2)
  );

  run_detect_fsm #(.RUN_LEN(4)) u_dut4 (
    .clk   (clk),
    .reset (reset4),
    .w     (w4),
    .z     (z4)
  );

  typedef struct {
    logic  rst;
    logic  w;
    logic  exp_z;
    string name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: z=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge
  task automatic step2(input logic rst, input logic wv, input logic exp, input string name);
    @(negedge clk);
    reset2 = rst;
    w2     = wv;
    @(posedge clk);
    #1;
    check(name, z2, exp);
  endtask

  task automatic step4(input logic rst, input logic wv, input logic exp, input string name);
    @(negedge clk);
    reset4 = rst;
    w4     = wv;
    @(posedge clk);
    #1;
    check(name, z4, exp);
  endtask

  task automatic add(input logic rst, input logic wv, input logic exp, input string name);
    vec_t v;
    v.rst   = rst;
    v.w     = wv;
    v.exp_z = exp;
    v.name  = name;
    vecs.push_back(v);
  endtask

  initial begin
    logic [8:0] mix_w;
    logic [8:0] mix_z;
    logic [8:0] r4_w;
    logic [8:0] r4_z;

    // Reset held with w=1, then one w=1 sample: run length 1 only
    add(1'b1, 1'b1, 1'b0, "reset_edge1");
    add(1'b1, 1'b1, 1'b0, "reset_edge2");
    add(1'b0, 1'b1, 1'b0, "first_after_reset");

    // Mixed sequence, listed MSB-first as applied: 0,0,1,0,1,1,1,0,0
    add(1'b1, 1'b0, 1'b0, "mix_reset");
    mix_w = 9'b001011100;
    mix_z = 9'b010001101;
    for (int i = 8; i >= 0; i--) begin
      add(1'b0, mix_w[i], mix_z[i], $sformatf("mix_%0d", 8 - i));
    end

    // Alternating 0,1,0,1,... never forms a run
    add(1'b1, 1'b0, 1'b0, "alt_reset");
    for (int i = 0; i < 16; i++) begin
      add(1'b0, logic'(i % 2), 1'b0, $sformatf("alt_%0d", i));
    end

    // Apply the table
    for (int i = 0; i < vecs.size(); i++) begin
      step2(vecs[i].rst, vecs[i].w, vecs[i].exp_z, vecs[i].name);
    end

    // Saturation: 20 ones, z must never drop after edge 2
    step2(1'b1, 1'b0, 1'b0, "sat_reset");
    for (int i = 1; i <= 20; i++) begin
      step2(1'b0, 1'b1, (i >= 2) ? 1'b1 : 1'b0, $sformatf("sat_%0d", i));
    end

    // Glitch on w between edges must not move z
    @(negedge clk);
    w2 = 1'b0;
    #2;
    check("glitch_low", z2, 1'b1);
    w2 = 1'b1;
    #1;
    check("glitch_back", z2, 1'b1);

    // Reset mid-run discards history
    step2(1'b1, 1'b0, 1'b0, "mid_reset0");
    step2(1'b0, 1'b0, 1'b0, "mid_w0a");
    step2(1'b0, 1'b0, 1'b1, "mid_w0b");
    step2(1'b1, 1'b0, 1'b0, "mid_reset1");
    step2(1'b0, 1'b0, 1'b0, "mid_after_a");
    step2(1'b0, 1'b0, 1'b1, "mid_after_b");

    // RUN_LEN=4: 1,1,1,1,1,0,0,0,0 -> 0,0,0,1,1,0,0,0,1
    step4(1'b1, 1'b1, 1'b0, "r4_reset");
    r4_w = 9'b111110000;
    r4_z = 9'b000110001;
    for (int i = 8; i >= 0; i--) begin
      step4(1'b0, r4_w[i], r4_z[i], $sformatf("r4_%0d", 8 - i));
    end
    // A run of three after a break must not trigger
    step4(1'b0, 1'b1, 1'b0, "r4_break");
    step4(1'b0, 1'b1, 1'b0, "r4_two");
    step4(1'b0, 1'b1, 1'b0, "r4_three");
    step4(1'b0, 1'b0, 1'b0, "r4_break2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
